// File: rtl/mem_responder.sv
// mem_responder: word-addressed 2^DEPTH_LOG2 x 32 memory slave claiming a window at BASE_ADDR.
// Latency: dn is presented WAIT_CYCLES+1 clocks after claim, counting the claim edge (1 clock without MEM_RESP_WAIT_EN).
// Backpressure: none; a request still held after completion parks the FSM in RELEASE until both request lines drop.
// Optional feature: define MEM_RESP_WAIT_EN to enable WAIT_CYCLES wait states (undefined: DONE follows the claim edge).
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        read_q,
  input  logic        write_q,
  input  logic        halt_q,
  output logic [31:0] data_out,
  output logic        read_dn,
  output logic        write_dn,
  output logic        is_bus_busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            wait_cnt;
  logic [3:0]            wait_cnt_nxt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  is_wr_q;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           offset;
  logic                  hit;
  logic                  rd_req;
  logic                  wr_req;
  logic                  claim;
  logic                  done_rd;
  logic                  done_wr;
  logic                  unused_halt;

  // Only a solid 1 on a request line counts; x/z are treated as idle.
  assign rd_req = (read_q === 1'b1);
  assign wr_req = (write_q === 1'b1);

  // Unsigned difference wraps addresses below the base to huge values, so one compare covers both ends.
  assign offset = addr_in - BASE_ADDR;
  assign hit    = ((offset >> DEPTH_LOG2) == 32'd0);
  assign claim  = (state == S_IDLE) && (rd_req || wr_req) && hit;

  // halt_q belongs to the requester's arbitration and does not affect responses.
  assign unused_halt = halt_q;

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (claim) begin
          wait_cnt_nxt = 4'(WAIT_CYCLES);
`ifdef MEM_RESP_WAIT_EN
          state_nxt    = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
`else
          state_nxt    = S_DONE;
`endif
        end
      end
      S_WAIT: begin
        // Request lines are deliberately not looked at here: the latched request completes.
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        wait_cnt_nxt = 4'd0;
        state_nxt    = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold here while the requester keeps asserting, so one request is serviced once.
        if (!rd_req && !wr_req) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and counter registers; synchronous reset aborts any open transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Capture index, data and direction on claim; write wins when both requests are high.
  always_ff @(posedge clk) begin
    if (claim) begin
      idx_q   <= offset[DEPTH_LOG2-1:0];
      wdata_q <= data_in;
      is_wr_q <= wr_req;
    end
  end

  assign done_rd = (state == S_DONE) && !is_wr_q;
  assign done_wr = (state == S_DONE) && is_wr_q;

  // Storage write at the end of DONE; a reset on that edge suppresses it. Contents are never reset.
  always_ff @(posedge clk) begin
    if (!rst && done_wr) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Bus outputs are only driven while asserted, otherwise released to high impedance.
  assign data_out    = done_rd ? mem[idx_q] : 32'hzzzz_zzzz;
  assign read_dn     = done_rd ? 1'b1 : 1'bz;
  assign write_dn    = done_wr ? 1'b1 : 1'bz;
  assign is_bus_busy = ((state == S_WAIT) || (state == S_DONE)) ? 1'b1 : 1'bz;

endmodule
